// File: rtl/uart_tx_serializer_if.sv
// Handshake and serial-line bundle for uart_tx_serializer.
// The master drives words in; the slave (the serializer) drives the line and status.
interface uart_tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              txd;
  logic              busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  txd,
    input  busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output txd,
    output busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_W bits LSB first, stop bit; all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the MSB and the stop bit.
module uart_tx_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_serializer_if.slave   bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              r_state;
  logic [DATA_W-1:0]   r_shiftReg;
  logic [CNT_W-1:0]    r_bitCnt;
  logic [IDX_W-1:0]    r_bitIdx;
  logic                r_txd;
  logic                r_ready;
  logic                r_busy;
`ifdef UART_TX_PARITY_EN
  logic                r_parity;
`endif

  logic w_bitEnd;

  assign w_bitEnd = (r_bitCnt == CNT_LAST);

  // txd is loaded one state ahead so the line changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shiftReg <= '0;
      r_bitCnt   <= '0;
      r_bitIdx   <= '0;
      r_txd      <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if (r_state != IDLE) begin
        r_bitCnt <= w_bitEnd ? '0 : r_bitCnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (bus.tx_valid) begin
            r_shiftReg <= bus.tx_data;
            r_bitCnt   <= '0;
            r_bitIdx   <= '0;
            r_txd      <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= START;
`ifdef UART_TX_PARITY_EN
            r_parity   <= ^bus.tx_data;
`endif
          end
        end

        START: begin
          if (w_bitEnd) begin
            r_txd   <= r_shiftReg[0];
            r_state <= DATA;
          end
        end

        DATA: begin
          if (w_bitEnd) begin
            r_shiftReg <= r_shiftReg >> 1;
            r_bitIdx   <= r_bitIdx + 1'b1;
            if (r_bitIdx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_txd   <= r_parity;
              r_state <= PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_txd <= r_shiftReg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bitEnd) begin
            r_txd   <= 1'b1;
            r_state <= STOP;
          end
        end
`endif

        STOP: begin
          if (w_bitEnd) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_txd   <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.txd      = r_txd;
  assign bus.tx_ready = r_ready;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer (DATA_W=8, CLKS_PER_BIT=4).
// Expected line levels are queued per cycle when a word is sent and compared against the captured line.
module tb_uart_tx_serializer;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F = (DATA_W + 3) * CPB;
`else
  localparam int F = (DATA_W + 2) * CPB;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic expQ[$];
  logic obsTxd[$];
  logic obsBusy[$];

  uart_tx_serializer_if #(.DATA_W(DATA_W)) bus ();

  uart_tx_serializer #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame: start, LSB-first data, optional even parity, stop; one entry per clock.
  function automatic void pushFrame(input logic [DATA_W-1:0] d);
    for (int i = 0; i < CPB; i++) expQ.push_back(1'b0);
    for (int k = 0; k < DATA_W; k++)
      for (int i = 0; i < CPB; i++) expQ.push_back(d[k]);
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < CPB; i++) expQ.push_back(^d);
`endif
    for (int i = 0; i < CPB; i++) expQ.push_back(1'b1);
  endfunction

  // Waits (bounded) for tx_ready, presents the word, and returns in the first START cycle.
  task automatic acceptWord(input logic [DATA_W-1:0] d);
    for (int i = 0; i < 200 && bus.tx_ready !== 1'b1; i++) @(negedge clk);
    if (bus.tx_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: tx_ready=%b expected 1", bus.tx_ready);
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    pushFrame(d);
    @(negedge clk);
  endtask

  task automatic captureFrame(input int n);
    obsTxd.delete();
    obsBusy.delete();
    for (int i = 0; i < n; i++) begin
      obsTxd.push_back(bus.txd);
      obsBusy.push_back(bus.busy);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({bus.txd, bus.tx_ready, bus.busy} !== 3'b110) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs: txd/ready/busy=%b expected 110",
                 {bus.txd, bus.tx_ready, bus.busy});
      end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame;
    logic e;
    acceptWord(8'hA5);
    bus.tx_valid = 1'b0;
    captureFrame(F);
    for (int i = 0; i < F; i++) begin
      e = expQ.pop_front();
      vectors += 2;
      if (obsTxd[i] !== e) begin
        miscompares++;
        $display("[TB] FAIL a5_txd cycle %0d: got %b expected %b", i, obsTxd[i], e);
      end
      if (obsBusy[i] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL a5_busy cycle %0d: got %b expected 1", i, obsBusy[i]);
      end
    end
    vectors++;
    if ({bus.txd, bus.tx_ready, bus.busy} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL a5_end: txd/ready/busy=%b expected 110",
               {bus.txd, bus.tx_ready, bus.busy});
    end
  endtask

  task automatic test_back_to_back;
    logic e;
    acceptWord(8'h00);
    bus.tx_data = 8'hFF;
    captureFrame(F);
    for (int i = 0; i < F; i++) begin
      e = expQ.pop_front();
      vectors++;
      if (obsTxd[i] !== e) begin
        miscompares++;
        $display("[TB] FAIL b2b_first_txd cycle %0d: got %b expected %b", i, obsTxd[i], e);
      end
    end
    // Exactly one idle-high cycle, then the held FF word must already be starting.
    vectors++;
    if ({bus.txd, bus.tx_ready, bus.busy} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL b2b_gap: txd/ready/busy=%b expected 110",
               {bus.txd, bus.tx_ready, bus.busy});
    end
    pushFrame(8'hFF);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    captureFrame(F);
    for (int i = 0; i < F; i++) begin
      e = expQ.pop_front();
      vectors++;
      if (obsTxd[i] !== e) begin
        miscompares++;
        $display("[TB] FAIL b2b_second_txd cycle %0d: got %b expected %b", i, obsTxd[i], e);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic e;
    logic [DATA_W-1:0] words [2];
    logic              parExp [2];
    words[0] = 8'h07; parExp[0] = 1'b1;
    words[1] = 8'h03; parExp[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      acceptWord(words[w]);
      bus.tx_valid = 1'b0;
      captureFrame(F);
      for (int i = 0; i < F; i++) begin
        e = expQ.pop_front();
        vectors++;
        if (obsTxd[i] !== e) begin
          miscompares++;
          $display("[TB] FAIL parity_txd word %0d cycle %0d: got %b expected %b", w, i, obsTxd[i], e);
        end
      end
      vectors += 2;
      if (obsTxd[(1 + DATA_W) * CPB] !== parExp[w]) begin
        miscompares++;
        $display("[TB] FAIL parity_bit word %0d: got %b expected %b",
                 w, obsTxd[(1 + DATA_W) * CPB], parExp[w]);
      end
      if (bus.busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL parity_len word %0d: busy=%b expected 0 after 44 cycles", w, bus.busy);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    logic e;
    acceptWord(8'h5A);
    bus.tx_valid = 1'b0;
    captureFrame((1 + 3) * CPB + 1);
    for (int i = 0; i < (1 + 3) * CPB + 1; i++) begin
      e = expQ.pop_front();
      vectors++;
      if (obsTxd[i] !== e) begin
        miscompares++;
        $display("[TB] FAIL midrst_pre_txd cycle %0d: got %b expected %b", i, obsTxd[i], e);
      end
    end
    expQ.delete();
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({bus.txd, bus.tx_ready, bus.busy} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: txd/ready/busy=%b expected 110",
               {bus.txd, bus.tx_ready, bus.busy});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    acceptWord(8'h3C);
    bus.tx_valid = 1'b0;
    captureFrame(F);
    for (int i = 0; i < F; i++) begin
      e = expQ.pop_front();
      vectors++;
      if (obsTxd[i] !== e) begin
        miscompares++;
        $display("[TB] FAIL midrst_after_txd cycle %0d: got %b expected %b", i, obsTxd[i], e);
      end
    end
  endtask

  task automatic test_ignored_inputs;
    logic e;
    acceptWord(8'h96);
    fork
      captureFrame(F);
      begin
        for (int i = 0; i < F - 1; i++) begin
          #2;
          bus.tx_valid = 1'($urandom_range(0, 1));
          bus.tx_data  = DATA_W'($urandom);
          @(negedge clk);
        end
        #2 bus.tx_valid = 1'b0;
      end
    join
    for (int i = 0; i < F; i++) begin
      e = expQ.pop_front();
      vectors += 2;
      if (obsTxd[i] !== e) begin
        miscompares++;
        $display("[TB] FAIL ignored_txd cycle %0d: got %b expected %b", i, obsTxd[i], e);
      end
      if (obsBusy[i] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL ignored_busy cycle %0d: got %b expected 1", i, obsBusy[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if ({bus.txd, bus.tx_ready, bus.busy} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL ignored_no_extra: txd/ready/busy=%b expected 110",
               {bus.txd, bus.tx_ready, bus.busy});
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    test_reset;
    test_single_frame;
    test_back_to_back;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    test_reset_mid_frame;
    test_ignored_inputs;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Parallel-to-serial UART transmitter. Accepts one DATA_W-bit word per valid/ready handshake and shifts it out on a single line, LSB first, framed by a start bit and a stop bit. It is the transmit end of the serial link whose receive end captures `txd` through flip-flops. Built on the same single-clock, flip-flop-per-state style as the team's storage primitives.

## Interface
- DATA_W, 8: payload bits per frame; legal range 5–9.
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be ≥ 2.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-low reset; one clock, no other reset.
- tx_data  input  DATA_W  word to send; sampled only at acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- txd  output  1  serial line; idle high.
- busy  output  1  frame in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: txd=1, tx_ready=1, busy=0.
- Acceptance: the rising edge where tx_valid=1 and tx_ready=1 loads tx_data into the shift register, clears the bit-cycle counter and the bit index, and moves to START.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: txd=shift_reg[0]. Every CLKS_PER_BIT cycles the register shifts right and the index increments. After DATA_W bits the FSM moves to PARITY or STOP.
- PARITY: txd=^captured_data (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
- tx_ready=1 only in IDLE. busy=1 in every non-IDLE state. tx_valid and tx_data are ignored outside IDLE.
- Bit-cycle counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on the last cycle of each bit. The bit index is $clog2(DATA_W+1) bits wide.
- Reset asserted at any time, including mid-frame, takes effect asynchronously:
  - state=IDLE, txd=1, tx_ready=1, busy=0.
  - Shift register and counters cleared.
  - The partial frame is abandoned and is never resumed.

## Timing
- Reset values: txd=1, tx_ready=1, busy=0.
- Start bit begins on the first clk edge after acceptance. txd is registered, so there is no combinational path from tx_valid or tx_data to txd.
- Frame length is F×CLKS_PER_BIT cycles. F=DATA_W+2 without parity and DATA_W+3 with parity.
- tx_ready rises on the edge that ends STOP. A word held valid at that point is accepted one cycle later, so the minimum gap between frames is 1 idle cycle (txd=1).
- Bit k of tx_data (k=0..DATA_W-1) is driven during cycles [(1+k)×CLKS_PER_BIT, (2+k)×CLKS_PER_BIT) counted from the first START cycle.
- Changes to tx_data after acceptance have no effect on the current frame.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state compiled in; one even-parity bit is inserted between the MSB and the stop bit.
  - F=DATA_W+3.
- UART_TX_PARITY_EN undefined:
  - No PARITY state and no parity logic.
  - F=DATA_W+2.

## Test plan
All scenarios use DATA_W=8 and CLKS_PER_BIT=4.
- Reset: hold rst=0 for 3 cycles -> txd=1, tx_ready=1, busy=0 throughout; no parity build.
- Single frame: send 8'hA5 with no parity -> txd over 40 cycles is 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles. busy=1 for 40 cycles, then tx_ready=1.
- Back-to-back: hold tx_valid=1 with 8'h00 then 8'h FF -> exactly 1 idle-high cycle between frames. The second frame carries eight 1 bits.
- Parity: with UART_TX_PARITY_EN, send 8'h07 -> parity bit 1 and a 44-cycle frame. Send 8'h03 -> parity bit 0.
- Reset mid-frame: assert rst during bit 3 of 8'h5A -> txd=1 and busy=0 in the same cycle. After release, the next accepted 8'h3C is sent intact.
- Ignored inputs: toggle tx_valid and change tx_data during a frame -> the frame is unchanged, and no extra word is accepted until tx_ready=1.
